// File: rtl/fifo_read_control_if.sv
// Read-side bus of the async FIFO: request, synchronised pointers, memory port and status.
// The master drives requests, the write pointer and memory data; the slave is the controller.
interface fifo_read_control_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              rd_en;
    logic [ADDR_W:0]   wr_ptr_gray;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    modport master (
        output rd_en, wr_ptr_gray, mem_rdata,
        input  mem_raddr, rd_ptr_gray, dout, dout_valid, empty, almost_empty, rd_count,
               underflow
    );

    modport slave (
        input  rd_en, wr_ptr_gray, mem_rdata,
        output mem_raddr, rd_ptr_gray, dout, dout_valid, empty, almost_empty, rd_count,
               underflow
    );
endinterface

// File: rtl/fifo_read_control.sv
// Destination-domain controller of the dual-clock FIFO: synchronises the write pointer,
// tracks occupancy, accepts reads, registers read data and exports a Gray read pointer.
module fifo_read_control #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_LEVEL    = 1
) (
    input logic                clk_d_i,
    input logic                rst_n_i,
    fifo_read_control_if.slave bus
);
    localparam logic [ADDR_W:0] AeLevel = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] PtrOne  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   sync_q [SYNC_STAGES];
    logic [ADDR_W:0]   wbin_s;
    logic [ADDR_W:0]   rd_count;
    logic              empty;
    logic              accept;

    logic [ADDR_W:0]   rd_bin_q, rd_bin_d;
    logic [ADDR_W:0]   rd_gray_q, rd_gray_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              underflow_q, underflow_d;

    // Write-pointer synchroniser; only the last stage feeds any logic.
    always_ff @(posedge clk_d_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.wr_ptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= int'(ADDR_W); i++) begin
            wbin_s[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end
    end

    assign rd_count = wbin_s - rd_bin_q;
    assign empty    = (rd_count == '0);
    assign accept   = bus.rd_en && !empty;

    always_comb begin
        rd_bin_d     = rd_bin_q;
        rd_gray_d    = rd_gray_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        underflow_d  = 1'b0;
        if (accept) begin
            rd_bin_d     = rd_bin_q + PtrOne;
            rd_gray_d    = rd_bin_d ^ (rd_bin_d >> 1);
            dout_d       = bus.mem_rdata;
            dout_valid_d = 1'b1;
        end else if (bus.rd_en) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_d_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_bin_q     <= '0;
            rd_gray_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rd_bin_q     <= rd_bin_d;
            rd_gray_q    <= rd_gray_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.mem_raddr    = rd_bin_q[ADDR_W-1:0];
    assign bus.rd_ptr_gray  = rd_gray_q;
    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.empty        = empty;
    assign bus.almost_empty = (rd_count <= AeLevel);
    assign bus.rd_count     = rd_count;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_read_control.sv
// Directed bench for fifo_read_control with a read-data scoreboard and a small pointer model.
module tb_fifo_read_control;
    logic clk;
    logic rst_n;

    fifo_read_control_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    fifo_read_control #(
        .DATA_W(8),
        .ADDR_W(3),
        .SYNC_STAGES(2),
        .AE_LEVEL(1)
    ) dut (
        .clk_d_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );

    assign bus.mem_rdata = 8'hA0 + {5'b0, bus.mem_raddr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [3:0] rd_bin_m;
    logic [3:0] cnt_m;
    logic [7:0] last_dout_m;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'(gray(rd_bin_m)));
        chk("rd_count", 32'(bus.rd_count), 32'(cnt_m));
        chk("empty", 32'(bus.empty), 32'(cnt_m == 4'd0));
        chk("almost_empty", 32'(bus.almost_empty), 32'(cnt_m <= 4'd1));
        chk("mem_raddr", 32'(bus.mem_raddr), 32'(rd_bin_m[2:0]));
        chk("dout_hold", 32'(bus.dout), 32'(last_dout_m));
    endtask

    // One clock with rd_en = en; expectations come from the model count visible before the edge.
    task automatic rd_cycle(input logic en);
        logic acc;
        logic uf;
        bus.rd_en = en;
        acc = en && (cnt_m != 4'd0);
        uf  = en && (cnt_m == 4'd0);
        if (acc) begin
            exp_q.push_back(8'hA0 + {5'b0, rd_bin_m[2:0]});
            rd_bin_m = rd_bin_m + 4'd1;
            cnt_m    = cnt_m - 4'd1;
        end
        @(posedge clk);
        #1;
        chk("dout_valid", 32'(bus.dout_valid), 32'(acc));
        chk("underflow", 32'(bus.underflow), 32'(uf));
        if (acc && exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("dout", 32'(bus.dout), 32'(e));
            last_dout_m = e;
        end
        chk_state();
    endtask

    // New write pointer must stay invisible for one edge and appear on the second.
    task automatic set_wr(input logic [3:0] wbin);
        bus.wr_ptr_gray = gray(wbin);
        rd_cycle(1'b0);
        cnt_m = wbin - rd_bin_m;
        rd_cycle(1'b0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
        chk("rst_rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_underflow", 32'(bus.underflow), 32'd0);
        chk("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    endtask

    initial begin
        rd_bin_m        = '0;
        cnt_m           = '0;
        last_dout_m     = '0;
        rst_n           = 1'b0;
        bus.rd_en       = 1'($urandom);
        bus.wr_ptr_gray = 4'($urandom);
        #2;
        chk_reset_vals();
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.rd_en       = 1'($urandom);
            bus.wr_ptr_gray = 4'($urandom);
        end
        chk_reset_vals();
        bus.rd_en       = 1'b0;
        bus.wr_ptr_gray = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_cycle(1'b0);

        // Synchroniser latency, then a 3-word burst that runs into underflow.
        set_wr(4'd3);
        repeat (3) rd_cycle(1'b1);
        rd_cycle(1'b1);
        rd_cycle(1'b0);

        // Walk rd_bin to 15, then wrap with the write pointer at 1.
        set_wr(4'd11);
        repeat (8) rd_cycle(1'b1);
        set_wr(4'd15);
        repeat (4) rd_cycle(1'b1);
        set_wr(4'd1);
        chk("wrap_count", 32'(bus.rd_count), 32'd2);
        rd_cycle(1'b1);
        chk("wrap_dout0", 32'(bus.dout), 32'hA7);
        rd_cycle(1'b1);
        chk("wrap_dout1", 32'(bus.dout), 32'hA0);
        chk("wrap_gray", 32'(bus.rd_ptr_gray), 32'b0001);
        rd_cycle(1'b0);

        // Mid-cycle reset with four words pending and a read requested.
        set_wr(4'd5);
        chk("pre_rst_count", 32'(bus.rd_count), 32'd4);
        bus.rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        bus.rd_en       = 1'b0;
        bus.wr_ptr_gray = 4'b0001;
        exp_q.delete();
        rd_bin_m    = '0;
        cnt_m       = '0;
        last_dout_m = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_wr(4'd1);
        rd_cycle(1'b1);
        chk("post_rst_dout", 32'(bus.dout), 32'hA0);
        rd_cycle(1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_read_control.md
# fifo_read_control

Parametrised read-side controller for the dual-clock asynchronous FIFO, running entirely in the destination (read) clock domain. It synchronises the Gray-coded write pointer from the source domain and derives occupancy, empty and almost-empty. It accepts read requests, drives the memory read address and registers the read data, and returns its own Gray-coded read pointer to the write domain. It generalises the fixed 8-bit, depth-8 destination controller with configurable width, depth and synchroniser length, plus underflow reporting and data-valid signalling.

## Interface
- DATA_W, 8, data word width.
- ADDR_W, 3, memory address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flip-flop stages in the write-pointer synchroniser; legal values ≥2.
- AE_LEVEL, 1, almost-empty threshold in words; legal range 0..2**ADDR_W.

Ports:
- clk_d  in  1  destination clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- wr_ptr_gray  in  ADDR_W+1  write pointer from the source domain, Gray coded, asynchronous to clk_d.
- mem_rdata  in  DATA_W  combinational read data from the FIFO memory at mem_raddr.
- mem_raddr  out  ADDR_W  memory read address; equals rd_bin[ADDR_W-1:0].
- rd_ptr_gray  out  ADDR_W+1  registered Gray-coded read pointer, sent to the write domain.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  one-cycle pulse; dout holds a newly read word.
- empty  out  1  no readable words.
- almost_empty  out  1  rd_count ≤ AE_LEVEL.
- rd_count  out  ADDR_W+1  readable words, 0..2**ADDR_W.
- underflow  out  1  one-cycle pulse; rd_en was asserted while empty.

## Operation
- Synchroniser: wr_ptr_gray passes through SYNC_STAGES reset-to-0 flops. Only the final stage is used.
- Gray-to-binary conversion of the synchronised pointer gives wbin_s. This is combinational and has ADDR_W+1 bits.
- rd_bin is the binary read pointer register (ADDR_W+1 bits). rd_ptr_gray is a separate register, loaded with gray(rd_bin_next) on each accepted read, so it never glitches.
- rd_count = wbin_s − rd_bin, computed modulo 2**(ADDR_W+1). It is combinational from registers.
- empty = (rd_count == 0). almost_empty = (rd_count ≤ AE_LEVEL).
- Accept condition: rd_en && !empty. On accept:
  - rd_bin increments and wraps from 2**(ADDR_W+1)−1 to 0.
  - rd_ptr_gray updates.
  - dout <= mem_rdata.
  - dout_valid <= 1.
- rd_en while empty: underflow <= 1; dout_valid <= 0; pointers and dout are unchanged.
- No request (rd_en = 0): dout_valid <= 0 and underflow <= 0; dout holds its value.
- Empty is pessimistic. A write becomes visible only after synchronisation, and the block never reads an unwritten location.
- rd_count is never negative and never exceeds 2**ADDR_W when the write side obeys its own full rule.

## Timing
- Reset (rst_n = 0, asynchronous) sets the following immediately:
  - all synchroniser flops, rd_bin, rd_ptr_gray, dout, dout_valid and underflow to 0;
  - therefore rd_count = 0, empty = 1, almost_empty = 1, mem_raddr = 0.
- Reset asserted mid-operation discards all in-flight state. The first read after release returns the word at address 0.
- Write-pointer latency: a change on wr_ptr_gray (stable at the sampling edge) appears in rd_count/empty after exactly SYNC_STAGES rising edges of clk_d.
- Read latency: mem_raddr is valid in the request cycle. dout and dout_valid update at the same edge that accepts the read, so data is visible 1 cycle after rd_en.
- Back-to-back reads sustain one word per cycle while rd_count > 0.
- Last-word case: a read that makes rd_count 0 asserts empty in the following cycle. A rd_en held into that cycle produces underflow.
- A write arriving in the same cycle as a read: rd_count reflects the read immediately and the write after synchronisation. No word is lost or duplicated.

## Test plan
Parameters for all scenarios: DATA_W=8, ADDR_W=3, SYNC_STAGES=2, AE_LEVEL=1. The memory model returns 0xA0+mem_raddr.

- Reset: rst_n=0 with random inputs -> empty=1, almost_empty=1, rd_count=0, rd_ptr_gray=0000, dout=0x00, dout_valid=0, underflow=0.
- Synchroniser latency: wr_ptr_gray=0010 (binary 3) -> rd_count stays 0 after 1 edge; after edge 2 rd_count=3, empty=0, almost_empty=0.
- Burst read: 3 consecutive rd_en cycles -> dout=0xA0,0xA1,0xA2 with dout_valid=1 each cycle; rd_ptr_gray=0001,0011,0010; then empty=1 and almost_empty=1. almost_empty is already 1 once rd_count=1.
- Underflow: rd_en=1 while empty -> underflow=1 for exactly one cycle; rd_ptr_gray, dout and mem_raddr are unchanged; dout_valid=0.
- Wrap-around: rd_bin=15, wbin_s=1 (gray 0001) -> rd_count=2. Two reads give dout=0xA7 then 0xA0, rd_ptr_gray goes 1000 -> 0000 -> 0001, then empty=1.
- Mid-operation reset: rst_n pulsed low while rd_count=4 and rd_en=1 -> all outputs return to reset values within the same cycle. After release, with wr_ptr_gray=0001, the first read returns 0xA0.
